// File: rtl/game_pkg.sv
// game_pkg: state encoding and object-mask helpers shared by the game sequencer.
package game_pkg;

    typedef enum logic [2:0] {IDLE, PHASE1, PHASE2, WIN, LOSE} state_t;

    localparam int         NUM_OBJ = 10;
    localparam logic [3:0] NO_HIT  = 4'd15;

    // Index 0 maps to the leftmost bit of a [0:NUM_OBJ-1] vector; 10..15 give an empty mask.
    function automatic logic [0:NUM_OBJ-1] obj_mask(input logic [3:0] idx);
        return (idx == NO_HIT) ? '0 : {1'b1, {(NUM_OBJ-1){1'b0}}} >> idx;
    endfunction

    function automatic logic [0:NUM_OBJ-1] first_clear(input logic [0:NUM_OBJ-1] v);
        logic [0:NUM_OBJ-1] m;
        m = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (!v[i]) m = obj_mask(4'(i));
        return m;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: counts frame starts while enabled and pulses expire on the frame reaching period.
module frame_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         startOfFrame,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] period,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   nxt;

    assign nxt    = {1'b0, cnt_q} + 1'b1;
    assign expire = enable && startOfFrame && (nxt >= {1'b0, period});

    always_comb
        cnt_d = clear ? '0 : (enable && startOfFrame) ? (expire ? '0 : nxt[W-1:0]) : cnt_q;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;

endmodule

// File: rtl/game_phase_sequencer.sv
// game_phase_sequencer: two-phase vaccine/corona game FSM with lives, score,
// invulnerability window and periodic corona spawning.
module game_phase_sequencer
    import game_pkg::*;
#(
    parameter int SPAWN_FRAMES  = 60,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_key,
    input  logic               hit_pulse,
    input  logic [3:0]         vaccine_idx,
    input  logic [3:0]         corona_idx,
    output logic [0:NUM_OBJ-1] active_vaccines,
    output logic [0:NUM_OBJ-1] active_coronas,
    output logic [7:0]         score,
    output logic [1:0]         lives,
    output logic [2:0]         phase,
    output logic               win,
    output logic               game_over
);

    localparam int TW = $clog2(SPAWN_FRAMES + 1);
    localparam int IW = $clog2(INVULN_FRAMES + 2);

    state_t             state_q, state_d;
    logic [0:NUM_OBJ-1] vac_q, vac_d, cor_q, cor_d;
    logic [7:0]         score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [IW-1:0]      inv_q, inv_d;

    logic               run, start, v_hit, c_hit, lose, adv, expire;
    logic [0:NUM_OBJ-1] vm, cm, vac_h, cor_h;
    logic [1:0]         lives_h;
    logic [TW-1:0]      period;

    // Post-hit values are formed outside the FSM block so the timer's clear never loops back through it.
    assign run     = (state_q == PHASE1) || (state_q == PHASE2);
    assign start   = (state_q == IDLE) && start_key;
    assign vm      = obj_mask(vaccine_idx);
    assign cm      = obj_mask(corona_idx);
    assign v_hit   = run && hit_pulse && |(vac_q & vm);
    assign c_hit   = run && hit_pulse && |(cor_q & cm) && (inv_q == '0);
    assign vac_h   = v_hit ? (vac_q & ~vm) : vac_q;
    assign cor_h   = c_hit ? (cor_q & ~cm) : cor_q;
    assign lives_h = c_hit ? lives_q - 2'd1 : lives_q;
    assign lose    = run && (lives_h == 2'd0);
    assign adv     = (state_q == PHASE1) && !lose && (vac_h == '0);
    assign period  = TW'((state_q == PHASE2) ? SPAWN_FRAMES / 2 : SPAWN_FRAMES);

    frame_timer #(.W(TW)) u_timer (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (run),
        .clear       (start || adv),
        .period      (period),
        .expire      (expire)
    );

    always_comb begin
        state_d = state_q;
        vac_d   = vac_q;
        cor_d   = cor_q;
        score_d = score_q;
        lives_d = lives_q;
        inv_d   = inv_q;
        if (start) begin
            state_d = PHASE1;
            vac_d   = '1;
            cor_d   = '0;
            score_d = '0;
            lives_d = 2'(START_LIVES);
            inv_d   = '0;
        end else if (run) begin
            vac_d   = adv ? '1 : vac_h;
            cor_d   = expire ? (cor_h | first_clear(cor_h)) : cor_h;
            score_d = (v_hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
            lives_d = lives_h;
            inv_d   = c_hit ? IW'(INVULN_FRAMES) : (startOfFrame && inv_q != '0) ? inv_q - 1'b1 : inv_q;
            state_d = lose ? LOSE : (vac_h == '0) ? ((state_q == PHASE1) ? PHASE2 : WIN) : state_q;
        end else if (start_key && (state_q == WIN || state_q == LOSE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state_q <= IDLE;
            vac_q   <= '0;
            cor_q   <= '0;
            score_q <= '0;
            lives_q <= '0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            vac_q   <= vac_d;
            cor_q   <= cor_d;
            score_q <= score_d;
            lives_q <= lives_d;
            inv_q   <= inv_d;
        end

    assign active_vaccines = vac_q;
    assign active_coronas  = cor_q;
    assign score           = score_q;
    assign lives           = lives_q;
    assign phase           = state_q;
    assign win             = (state_q == WIN);
    assign game_over       = (state_q == LOSE);

endmodule
